// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory responder.
//   mem_state_e : responder FSM states
//   mem_req_t   : captured request (address, direction, strobes, data)
//   MEM_LAT_W   : width of the wait-state counter (LATENCY 0..15)
package mem_pkg;

  localparam int unsigned MEM_LAT_W = 4;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// mem_array: word storage for the responder. Contents are not reset.
//   clk   : rising-edge clock
//   wr_en : commit a write this edge
//   waddr : write word index
//   wstrb : byte enables, bit i covers wdata[8i+7:8i]
//   wdata : write data
//   raddr : read word index (combinational read)
//   rdata : word at raddr
module mem_array #(
  parameter int unsigned WORDS = 16384,
  parameter int unsigned IDX_W = 14
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] waddr,
  input  logic [3:0]       wstrb,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory with fixed wait states.
// Optional build macro MEM_RESP_ERR_EN enables address-fault checking;
// without it rsp_err is always 0 and addresses alias modulo MEM_SIZE.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   req_valid/req_ready : request handshake
//   req_addr/we/wstrb/wdata : byte address, 1=store, byte enables, store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data (0 for stores and faults)
//   rsp_err             : access fault
//
// state    | meaning
// MEM_IDLE | ready for a request
// MEM_WAIT | counting wait states for the captured request
// MEM_RESP | response presented, held until rsp_ready
module mem_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned MEM_SIZE  = 65536,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned WORDS = MEM_SIZE / 4;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  mem_state_e           state;
  logic [MEM_LAT_W-1:0] cnt;
  mem_req_t             hold;
  mem_req_t             cur;
  logic                 accept;
  logic                 commit;
  logic                 fault;
  logic                 wr_en;
  logic [31:0]          offset;
  logic [IDX_W-1:0]     idx;
  logic [31:0]          arr_rdata;
  logic [31:0]          resp_data;

  assign accept = req_valid && req_ready;

  // With zero wait states the commit happens on the accept edge, so the
  // live request is used; otherwise the holding register is.
  always_comb begin
    cur = hold;
    if (state == MEM_IDLE) begin
      cur.addr  = req_addr;
      cur.we    = req_we;
      cur.wstrb = req_wstrb;
      cur.wdata = req_wdata;
    end
  end

  assign commit = (state == MEM_WAIT && cnt == MEM_LAT_W'(1)) ||
                  (accept && LATENCY == 0);

  assign offset = cur.addr - BASE_ADDR;
  // Masking gives the modulo wrap; in-range addresses are unaffected.
  assign idx    = IDX_W'((offset >> 2) & 32'(WORDS - 1));

`ifdef MEM_RESP_ERR_EN
  // offset is only compared once addr >= BASE_ADDR, so it cannot wrap.
  assign fault = (cur.addr < BASE_ADDR) || (offset >= MEM_SIZE) ||
                 (cur.addr[1:0] != 2'b00);
`else
  assign fault = 1'b0;
`endif

  assign wr_en     = commit && cur.we && !fault;
  assign resp_data = (cur.we || fault) ? 32'h0 : arr_rdata;

  mem_array #(
    .WORDS(WORDS),
    .IDX_W(IDX_W)
  ) u_array (
    .clk  (clk),
    .wr_en(wr_en),
    .waddr(idx),
    .wstrb(cur.wstrb),
    .wdata(cur.wdata),
    .raddr(idx),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MEM_IDLE;
      cnt       <= '0;
      hold      <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        MEM_IDLE: begin
          if (accept) begin
            hold      <= cur;
            cnt       <= MEM_LAT_W'(LATENCY);
            req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state     <= MEM_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= resp_data;
              rsp_err   <= fault;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          cnt <= cnt - MEM_LAT_W'(1);
          if (cnt == MEM_LAT_W'(1)) begin
            state     <= MEM_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= resp_data;
            rsp_err   <= fault;
          end
        end
        MEM_RESP: begin
          if (rsp_ready) begin
            state     <= MEM_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= MEM_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder. Instance dut uses the
// default two wait states and is tracked cycle by cycle by a transaction
// model; instance dut0 uses zero wait states and is checked against a table.
module tb_mem_responder;

  localparam logic [31:0] TB_BASE  = 32'h8000_0000;
  localparam int unsigned TB_SIZE  = 65536;
  localparam int unsigned TB_WORDS = TB_SIZE / 4;
  localparam int          TB_LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_wstrb;

  logic        r0_req_valid, r0_req_ready, r0_req_we, r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
  logic [31:0] r0_req_addr, r0_req_wdata, r0_rsp_rdata;
  logic [3:0]  r0_req_wstrb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.BASE_ADDR(TB_BASE), .MEM_SIZE(TB_SIZE), .LATENCY(TB_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_responder #(.BASE_ADDR(TB_BASE), .MEM_SIZE(TB_SIZE), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r0_req_valid), .req_ready(r0_req_ready), .req_addr(r0_req_addr),
    .req_we(r0_req_we), .req_wstrb(r0_req_wstrb), .req_wdata(r0_req_wdata),
    .rsp_valid(r0_rsp_valid), .rsp_ready(r0_rsp_ready), .rsp_rdata(r0_rsp_rdata),
    .rsp_err(r0_rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- transaction model for dut ----------------
  logic [31:0] mmem  [TB_WORDS];
  bit          mknown[TB_WORDS];
  bit          m_busy = 1'b0;
  bit          m_known = 1'b0;
  int          m_cyc = 0;
  int          m_due = 0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  bit          m_pend_we = 1'b0;
  int unsigned m_pend_idx = 0;
  logic [31:0] m_pend_data = '0;
  logic [3:0]  m_pend_strb = '0;

  function automatic bit is_fault(input logic [31:0] a);
`ifdef MEM_RESP_ERR_EN
    longint la;
    la = longint'(a);
    return (la < longint'(TB_BASE)) || (la >= longint'(TB_BASE) + longint'(TB_SIZE)) || (a % 4 != 0);
`else
    return (a === 32'hx);
`endif
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    int unsigned off;
    off = a - TB_BASE;
    return (off / 4) % TB_WORDS;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // m_cyc counts rising edges; a request accepted on edge n commits on edge
  // n+LAT and its response is visible from then until the handshake edge.
  always @(posedge clk) begin
    m_cyc <= m_cyc + 1;
    if (!rst_n) begin
      m_busy <= 1'b0;
    end else begin
      if (m_busy && m_pend_we && (m_cyc + 1 == m_due)) begin
        mmem[m_pend_idx] <= merge(mknown[m_pend_idx] ? mmem[m_pend_idx] : 32'h0,
                                  m_pend_data, m_pend_strb);
        mknown[m_pend_idx] <= 1'b1;
      end
      if (m_busy && m_cyc >= m_due && rsp_ready) begin
        m_busy <= 1'b0;
      end else if (!m_busy && req_valid) begin
        m_busy      <= 1'b1;
        m_due       <= m_cyc + 1 + TB_LAT;
        m_err       <= is_fault(req_addr);
        m_pend_we   <= req_we && !is_fault(req_addr);
        m_pend_idx  <= word_of(req_addr);
        m_pend_data <= req_wdata;
        m_pend_strb <= req_wstrb;
        if (req_we || is_fault(req_addr)) begin
          m_rdata <= 32'h0;
          m_known <= 1'b1;
        end else begin
          m_rdata <= mmem[word_of(req_addr)];
          m_known <= mknown[word_of(req_addr)];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("model_req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
      chk("model_rsp_valid", {31'b0, rsp_valid}, {31'b0, m_busy && m_cyc >= m_due});
      if (m_busy && m_cyc >= m_due) begin
        chk("model_rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
        if (m_known) chk("model_rsp_rdata", rsp_rdata, m_rdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xact(input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] d, input int stall,
                      output logic [31:0] rd, output logic er);
    int n;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_we = w; req_wstrb = s; req_wdata = d;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 32'(n), 32'd0);
      req_valid = 1'b0;
      rd = 'x;
      er = 1'bx;
      return;
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      req_valid = (stall > 0);
    end while (!rsp_valid && lat < 20);
    chk("rsp_latency", 32'(lat), 32'(TB_LAT + 1));
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_hs_rsp_valid", {31'b0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    logic        v;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic        ev;
    logic        erdy;
    logic [31:0] ed;
  } step_t;

  step_t tab [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;

    tab[0] = '{1'b1, 1'b1, 32'h8000_0100, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
    tab[1] = '{1'b1, 1'b1, 32'h8000_0104, 32'h0BAD_C0DE, 1'b0, 1'b1, 32'h0};
    tab[2] = '{1'b1, 1'b1, 32'h8000_0104, 32'h0BAD_C0DE, 1'b1, 1'b0, 32'h0};
    tab[3] = '{1'b1, 1'b0, 32'h8000_0100, 32'h0,         1'b0, 1'b1, 32'h0};
    tab[4] = '{1'b1, 1'b0, 32'h8000_0100, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D};
    tab[5] = '{1'b1, 1'b0, 32'h8000_0104, 32'h0,         1'b0, 1'b1, 32'h0};
    tab[6] = '{1'b1, 1'b0, 32'h8000_0104, 32'h0,         1'b1, 1'b0, 32'h0BAD_C0DE};
    tab[7] = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0};

    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wstrb = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    r0_req_valid = 1'b0; r0_req_addr = '0; r0_req_we = 1'b0; r0_req_wstrb = 4'hF;
    r0_req_wdata = '0; r0_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst0_req_ready", {31'b0, r0_req_ready}, 32'd1);

    // zero wait states, req_valid held high, rsp_ready always high
    for (int k = 0; k < 8; k++) begin
      r0_req_valid = tab[k].v; r0_req_we = tab[k].we;
      r0_req_addr = tab[k].a; r0_req_wdata = tab[k].d;
      @(negedge clk);
      chk($sformatf("lat0_rsp_valid_%0d", k), {31'b0, r0_rsp_valid}, {31'b0, tab[k].ev});
      chk($sformatf("lat0_req_ready_%0d", k), {31'b0, r0_req_ready}, {31'b0, tab[k].erdy});
      if (tab[k].ev) begin
        chk($sformatf("lat0_rdata_%0d", k), r0_rsp_rdata, tab[k].ed);
        chk($sformatf("lat0_err_%0d", k), {31'b0, r0_rsp_err}, 32'd0);
      end
    end

    // store then load
    xact(32'h8000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 0, rd, er);
    chk("store_rdata", rd, 32'h0);
    chk("store_err", {31'b0, er}, 32'd0);
    xact(32'h8000_0010, 1'b0, 4'h0, 32'h0, 0, rd, er);
    chk("load_rdata", rd, 32'hDEAD_BEEF);
    chk("load_err", {31'b0, er}, 32'd0);

    // byte strobes, then a store with no strobes
    xact(32'h8000_0020, 1'b1, 4'hF, 32'h1122_3344, 0, rd, er);
    xact(32'h8000_0020, 1'b1, 4'b0101, 32'hAABB_CCDD, 0, rd, er);
    xact(32'h8000_0020, 1'b0, 4'h0, 32'h0, 0, rd, er);
    chk("strobe_rdata", rd, 32'h11BB_33DD);
    xact(32'h8000_0020, 1'b1, 4'h0, 32'hFFFF_FFFF, 0, rd, er);
    chk("nostrobe_err", {31'b0, er}, 32'd0);
    xact(32'h8000_0020, 1'b0, 4'h0, 32'h0, 0, rd, er);
    chk("nostrobe_rdata", rd, 32'h11BB_33DD);

    // backpressure with a second request pending
    xact(32'h8000_0010, 1'b0, 4'h0, 32'h0, 5, rd, er);
    chk("bp_rdata", rd, 32'hDEAD_BEEF);

    // faults / aliasing
    xact(32'h8000_0000, 1'b1, 4'hF, 32'h5A5A_5A5A, 0, rd, er);
`ifdef MEM_RESP_ERR_EN
    xact(32'h7FFF_FFFC, 1'b0, 4'h0, 32'h0, 0, rd, er);
    chk("fault_low_err", {31'b0, er}, 32'd1);
    chk("fault_low_rdata", rd, 32'h0);
    xact(32'h8000_0002, 1'b0, 4'h0, 32'h0, 0, rd, er);
    chk("fault_align_err", {31'b0, er}, 32'd1);
    chk("fault_align_rdata", rd, 32'h0);
    xact(32'h8001_0000, 1'b1, 4'hF, 32'h1234_5678, 0, rd, er);
    chk("fault_high_err", {31'b0, er}, 32'd1);
    xact(32'h8000_0000, 1'b0, 4'h0, 32'h0, 0, rd, er);
    chk("fault_nochange_rdata", rd, 32'h5A5A_5A5A);
    chk("fault_nochange_err", {31'b0, er}, 32'd0);
`else
    xact(32'h8001_0000, 1'b1, 4'hF, 32'h1234_5678, 0, rd, er);
    chk("alias_store_err", {31'b0, er}, 32'd0);
    xact(32'h8000_0000, 1'b0, 4'h0, 32'h0, 0, rd, er);
    chk("alias_rdata", rd, 32'h1234_5678);
`endif

    // reset during the wait states of a store
    xact(32'h8000_0040, 1'b1, 4'hF, 32'h0102_0304, 0, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8000_0040; req_we = 1'b1;
    req_wstrb = 4'hF; req_wdata = 32'hFFFF_0000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_req_ready", {31'b0, req_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    xact(32'h8000_0040, 1'b0, 4'h0, 32'h0, 0, rd, er);
    chk("mid_rst_old_rdata", rd, 32'h0102_0304);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
